// File: rtl/load_store_unit.sv
// load_store_unit: lb/lh/lw/lbu/lhu/sb/sh/sw sequencer in front of a word-wide memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned or illegal-funct3 accesses via oFault.
module load_store_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        iReq,
  input  logic        iWrite,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddress,
  input  logic [31:0] iData,
  output logic        oReady,
  output logic        oDone,
  output logic [31:0] oData,
  output logic        oFault,
  output logic [31:0] oMemAddress,
  output logic [31:0] oMemData,
  output logic        oMemWrite,
  output logic        oMemRead,
  input  logic [31:0] iMemData
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_data;

  logic        w_in_sub;
  logic        w_in_fault;
  logic        w_byte;
  logic        w_half;
  logic [7:0]  w_byte_lane;
  logic [15:0] w_half_lane;
  logic [31:0] w_load_val;
  logic [31:0] w_merged;

  // funct3 011/110/111 have bit 1 set, so they fall into the word path
  assign w_in_sub = ~iFunct3[1];
  assign w_byte   = (r_funct3[1:0] == 2'b00);
  assign w_half   = (r_funct3[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_fault;

  assign w_in_fault = (iFunct3 == 3'b011) || (iFunct3 == 3'b110) || (iFunct3 == 3'b111) ||
                      ((iFunct3[1:0] == 2'b01) && iAddress[0]) ||
                      ((iFunct3[1:0] == 2'b10) && (iAddress[1:0] != 2'b00));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_fault <= 1'b0;
    else if (r_state == S_IDLE && iReq)
      r_fault <= w_in_fault;
  end

  assign oFault = (r_state == S_DONE) && r_fault;
`else
  assign w_in_fault = 1'b0;
  assign oFault     = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (iReq) begin
          if (w_in_fault)
            w_state_next = S_DONE;
          else if (!iWrite)
            w_state_next = S_LOAD;
          else if (w_in_sub)
            w_state_next = S_RMW_RD;
          else
            w_state_next = S_WRITE;
        end
      end
      S_LOAD:   w_state_next = S_DONE;
      S_RMW_RD: w_state_next = S_WRITE;
      S_WRITE:  w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_byte_lane = iMemData[{r_addr[1:0], 3'b000} +: 8];
    w_half_lane = iMemData[{r_addr[1], 4'b0000} +: 16];
    if (w_byte)
      w_load_val = r_funct3[2] ? {24'b0, w_byte_lane} : {{24{w_byte_lane[7]}}, w_byte_lane};
    else if (w_half)
      w_load_val = r_funct3[2] ? {16'b0, w_half_lane} : {{16{w_half_lane[15]}}, w_half_lane};
    else
      w_load_val = iMemData;
  end

  // r_wdata still holds the store data while in RMW_RD; it is replaced by the merged word
  always_comb begin
    w_merged = iMemData;
    if (w_byte)
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else if (w_half)
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_funct3 <= 3'b000;
      r_addr   <= 32'b0;
      r_wdata  <= 32'b0;
      r_data   <= 32'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iReq) begin
            r_funct3 <= iFunct3;
            r_addr   <= iAddress;
            r_wdata  <= iData;
          end
        end
        S_LOAD:   r_data  <= w_load_val;
        S_RMW_RD: r_wdata <= w_merged;
        default: ;
      endcase
    end
  end

  always_comb begin
    oReady      = 1'b0;
    oDone       = 1'b0;
    oMemRead    = 1'b0;
    oMemWrite   = 1'b0;
    oMemAddress = 32'b0;
    oMemData    = 32'b0;
    case (r_state)
      S_IDLE: oReady = 1'b1;
      S_LOAD, S_RMW_RD: begin
        oMemRead    = 1'b1;
        oMemAddress = {r_addr[31:2], 2'b00};
      end
      S_WRITE: begin
        oMemWrite   = 1'b1;
        oMemAddress = {r_addr[31:2], 2'b00};
        oMemData    = r_wdata;
      end
      S_DONE:  oDone = 1'b1;
      default: ;
    endcase
  end

  assign oData = r_data;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors, random accesses against a memory model,
// reset-during-write and back-to-back request sequences.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        iReq;
  logic        iWrite;
  logic [2:0]  iFunct3;
  logic [31:0] iAddress;
  logic [31:0] iData;
  logic        oReady;
  logic        oDone;
  logic [31:0] oData;
  logic        oFault;
  logic [31:0] oMemAddress;
  logic [31:0] oMemData;
  logic        oMemWrite;
  logic        oMemRead;
  logic [31:0] iMemData;

  load_store_unit dut (
    .clock(clock), .reset(reset), .iReq(iReq), .iWrite(iWrite), .iFunct3(iFunct3),
    .iAddress(iAddress), .iData(iData), .oReady(oReady), .oDone(oDone), .oData(oData),
    .oFault(oFault), .oMemAddress(oMemAddress), .oMemData(oMemData),
    .oMemWrite(oMemWrite), .oMemRead(oMemRead), .iMemData(iMemData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment memory: 64 words, combinational read, write on posedge, plus a backdoor preload port
  logic [31:0] mem [0:63];
  logic        bd_en;
  logic [5:0]  bd_idx;
  logic [31:0] bd_val;
  assign iMemData = mem[oMemAddress[7:2]];
  always @(posedge clock) begin
    if (oMemWrite)
      mem[oMemAddress[7:2]] <= oMemData;
    else if (bd_en)
      mem[bd_idx] <= bd_val;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [0:63];
  logic [31:0] last_load;

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    logic [31:0] exp_data;
    int          exp_lat;
    logic        exp_fault;
    logic [31:0] exp_word;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clock);
    bd_en  = 1'b1;
    bd_idx = idx;
    bd_val = val;
    @(posedge clock);
    #1 bd_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Reference rules, in bytes and plain arithmetic
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit model_fault(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (size_of(f3) == 2 && (addr % 2) != 0) return 1'b1;
    if (size_of(f3) == 4 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
`else
    return (f3 == 3'd0 && addr == 32'hFFFF_FFFF); // never true for the addresses used here
`endif
  endfunction

  function automatic int byte_off(input int sz, input logic [31:0] addr);
    if (sz == 1) return int'(addr % 4);
    return int'(((addr / 2) % 2) * 2);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] addr);
    int     sz;
    longint val;
    longint span;
    sz = size_of(f3);
    if (sz == 4) return word;
    span = longint'(1) << (8 * sz);
    val  = (longint'(word) >> (8 * byte_off(sz, addr))) % span;
    if (f3 < 4 && val >= span / 2) val = val - span;
    return val[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [2:0] f3,
                                              input logic [31:0] addr, input logic [31:0] data);
    int          sz;
    logic [31:0] mask;
    logic [63:0] ones;
    sz = size_of(f3);
    if (sz == 4) return data;
    ones = (64'd1 << (8 * sz)) - 64'd1;
    mask = ones[31:0] << (8 * byte_off(sz, addr));
    return (old & ~mask) | ((data << (8 * byte_off(sz, addr))) & mask);
  endfunction

  task automatic run_access(input string name, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_data, input int exp_lat,
                            input logic exp_fault, input logic [31:0] exp_word);
    int   lat;
    int   rd_cycles;
    int   wr_cycles;
    int   exp_rd;
    int   exp_wr;
    bit   done;
    bit   addr_ok;
    logic [31:0] word_after;
    exp_rd = (!exp_fault && (!wr || exp_lat == 3)) ? 1 : 0;
    exp_wr = (!exp_fault && wr) ? 1 : 0;
    @(negedge clock);
    chk({name, "_ready"}, 32'(oReady), 32'd1);
    iReq = 1'b1; iWrite = wr; iFunct3 = f3; iAddress = addr; iData = wdata;
    @(posedge clock);
    #1;
    iReq = 1'b0; iWrite = 1'($urandom); iFunct3 = 3'($urandom);
    iAddress = $urandom; iData = $urandom;
    lat = 1; rd_cycles = 0; wr_cycles = 0; done = 1'b0; addr_ok = 1'b1;
    while (!done && lat < 10) begin
      @(negedge clock);
      if (oDone) begin
        done = 1'b1;
      end else begin
        if (oMemRead)  rd_cycles++;
        if (oMemWrite) wr_cycles++;
        if (oMemAddress !== {addr[31:2], 2'b00}) addr_ok = 1'b0;
        @(posedge clock);
        lat++;
      end
    end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_rd_cycles"}, 32'(rd_cycles), 32'(exp_rd));
    chk({name, "_wr_cycles"}, 32'(wr_cycles), 32'(exp_wr));
    chk({name, "_mem_addr"}, 32'(addr_ok), 32'd1);
    chk({name, "_fault"}, 32'(oFault), 32'(exp_fault));
    chk({name, "_data"}, oData, exp_data);
    word_after = mem[addr[7:2]];
    chk({name, "_mem_word"}, word_after, exp_word);
    $display("txn %-10s wr=%0d f3=%0d addr=%h wdata=%h -> oData=%h word=%h lat=%0d fault=%0d",
             name, wr, f3, addr, wdata, oData, word_after, lat, oFault);
    @(posedge clock);
  endtask

  // Random access predicted from ref_mem and the reference rules
  task automatic model_access(input string name, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] old;
    logic [31:0] exp_data;
    logic [31:0] exp_word;
    int          lat;
    bit          flt;
    old = ref_mem[addr[7:2]];
    flt = model_fault(f3, addr);
    exp_data = last_load;
    exp_word = old;
    if (flt)                    lat = 1;
    else if (!wr)               lat = 2;
    else if (size_of(f3) == 4)  lat = 2;
    else                        lat = 3;
    if (!flt && !wr) exp_data = model_load(old, f3, addr);
    if (!flt && wr)  exp_word = model_store(old, f3, addr, wdata);
    run_access(name, wr, f3, addr, wdata, exp_data, lat, flt, exp_word);
    ref_mem[addr[7:2]] = exp_word;
    last_load = exp_data;
  endtask

  vec_t vecs [9];
  logic [2:0] ld_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
  logic [2:0] st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; iReq = 1'b0; iWrite = 1'b0; iFunct3 = 3'b0; iAddress = 32'b0; iData = 32'b0;
    bd_en = 1'b0; bd_idx = 6'b0; bd_val = 32'b0; last_load = 32'b0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'b0;
      ref_mem[i] = 32'b0;
    end

    vecs[0] = '{"lw_100",   1'b0, 3'd2, 32'h1001_0004, 32'h0,        32'd100,      32'd100,      2, 1'b0, 32'd100};
    vecs[1] = '{"sb_ab",    1'b1, 3'd0, 32'h1001_0001, 32'h0000_00AB, 32'h1122_3344, 32'd100,    3, 1'b0, 32'h1122_AB44};
    vecs[2] = '{"lb_p3",    1'b0, 3'd0, 32'h1001_0003, 32'h0,        32'h80FF_0000, 32'hFFFF_FF80, 2, 1'b0, 32'h80FF_0000};
    vecs[3] = '{"lbu_p3",   1'b0, 3'd4, 32'h1001_0003, 32'h0,        32'h80FF_0000, 32'h0000_0080, 2, 1'b0, 32'h80FF_0000};
    vecs[4] = '{"lh_p2",    1'b0, 3'd1, 32'h1001_0002, 32'h0,        32'h80FF_0000, 32'hFFFF_80FF, 2, 1'b0, 32'h80FF_0000};
    vecs[5] = '{"lhu_p2",   1'b0, 3'd5, 32'h1001_0002, 32'h0,        32'h80FF_0000, 32'h0000_80FF, 2, 1'b0, 32'h80FF_0000};
    vecs[6] = '{"sh_p2",    1'b1, 3'd1, 32'h1001_0002, 32'hCAFE_BEEF, 32'h1122_3344, 32'h0000_80FF, 3, 1'b0, 32'hBEEF_3344};
    vecs[7] = '{"sw_p8",    1'b1, 3'd2, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0,        32'h0000_80FF, 2, 1'b0, 32'hDEAD_BEEF};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[8] = '{"lw_mis",   1'b0, 3'd2, 32'h1001_0002, 32'h0,        32'hCAFE_F00D, 32'h0000_80FF, 1, 1'b1, 32'hCAFE_F00D};
`else
    vecs[8] = '{"lw_mis",   1'b0, 3'd2, 32'h1001_0002, 32'h0,        32'hCAFE_F00D, 32'hCAFE_F00D, 2, 1'b0, 32'hCAFE_F00D};
`endif

    // Reset values, observed while reset is held and after release
    #12;
    chk("rst_ready", 32'(oReady), 32'd1);
    chk("rst_done", 32'(oDone), 32'd0);
    chk("rst_data", oData, 32'd0);
    chk("rst_fault", 32'(oFault), 32'd0);
    chk("rst_memaddr", oMemAddress, 32'd0);
    chk("rst_memdata", oMemData, 32'd0);
    chk("rst_memwrite", 32'(oMemWrite), 32'd0);
    chk("rst_memread", 32'(oMemRead), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_ready", 32'(oReady), 32'd1);

    for (int i = 0; i < 9; i++) begin
      poke(vecs[i].addr[7:2], vecs[i].pre);
      run_access(vecs[i].name, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_data, vecs[i].exp_lat, vecs[i].exp_fault, vecs[i].exp_word);
      ref_mem[vecs[i].addr[7:2]] = vecs[i].exp_word;
      last_load = vecs[i].exp_data;
    end

    for (int i = 0; i < 16; i++) poke(6'(i), $urandom);
    for (int i = 0; i < 60; i++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      wr   = 1'($urandom);
      f3   = wr ? st_f3[$urandom_range(0, 5)] : ld_f3[$urandom_range(0, 7)];
      addr = 32'h1001_0000 + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      model_access("rand", wr, f3, addr, $urandom);
    end

    // Reset during WRITE of an sw: enable drops at once, word is untouched
    poke(6'd5, 32'h0123_4567);
    @(negedge clock);
    iReq = 1'b1; iWrite = 1'b1; iFunct3 = 3'd2; iAddress = 32'h1001_0014; iData = 32'hFFFF_FFFF;
    @(posedge clock);
    #1 iReq = 1'b0;
    @(negedge clock);
    chk("rstw_in_write", 32'(oMemWrite), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rstw_write_drop", 32'(oMemWrite), 32'd0);
    chk("rstw_addr_drop", oMemAddress, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    last_load = 32'b0;
    @(negedge clock);
    chk("rstw_mem_kept", mem[5], ref_mem[5]);
    chk("rstw_ready", 32'(oReady), 32'd1);
    chk("rstw_data_clr", oData, 32'd0);
    $display("txn rst_write  sw addr=10010014 interrupted by reset -> word=%h ready=%0d", mem[5], oReady);

    // iReq held high: an lw is accepted every third edge, requests in LOAD/DONE are dropped
    poke(6'd3, 32'h5A5A_1234);
    @(negedge clock);
    iReq = 1'b1; iWrite = 1'b0; iFunct3 = 3'd2; iAddress = 32'h1001_000C;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("b2b_done", 32'(oDone), (i % 3 == 1) ? 32'd1 : 32'd0);
      if (i % 3 == 1) chk("b2b_data", oData, 32'h5A5A_1234);
    end
    iReq = 1'b0;
    $display("txn b2b_lw     12 edges with iReq high -> last oData=%h", oData);

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
